// File: rtl/vector_reduction_unit.sv
// Multi-cycle vector reduction (RVV vred* style): folds one 64-bit chunk of vs2 per cycle
// into a SEW-wide accumulator seeded from vs1[0]. Optional element masking via VRED_MASK_EN.
module vector_reduction_unit #(
  parameter int unsigned VLEN = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [VLEN-1:0]            dataA,
  input  logic [VLEN-1:0]            dataB,
  input  logic [4:0]                 red_op,
  input  logic [1:0]                 sew,
  input  logic [$clog2(VLEN/8):0]    vl,
`ifdef VRED_MASK_EN
  input  logic [VLEN/8-1:0]          vmask,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [63:0]                result,
  output logic                       error
);

  localparam int unsigned IW  = $clog2(VLEN/8) + 1;
  localparam int unsigned NCH = VLEN / 64;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            busy_q, busy_d, done_q, done_d, error_q, error_d, err_q, err_d;
  logic [63:0]     result_q, result_d, acc_q, acc_d;
  logic [VLEN-1:0] b_q, b_d;
  logic [4:0]      op_q, op_d;
  logic [1:0]      sew_q, sew_d;
  logic [IW-1:0]   evl_q, evl_d;
  logic [CW-1:0]   c_q, c_d;
`ifdef VRED_MASK_EN
  logic [VLEN/8-1:0] vmask_q, vmask_d;
`endif

  logic            unsup_c, last_c, act_c;
  logic [IW-1:0]   maxel_c, evl_c, idx_c;
  logic [63:0]     chunk_c, fold_c, elem_c;

  function automatic logic [63:0] sew_mask(input logic [1:0] s);
    sew_mask = (s == 2'd3) ? '1 : ((64'(1) << (7'd8 << s)) - 64'd1);
  endfunction

  // Operands are already zero-extended SEW values; signed compare flips the SEW sign bit.
  function automatic logic [63:0] red_apply(input logic [63:0] a, input logic [63:0] b,
                                            input logic [4:0] op, input logic [1:0] s);
    logic [63:0] sb;
    logic        bgt_u, bgt_s;
    sb    = 64'(1) << ((7'd8 << s) - 7'd1);
    bgt_u = b > a;
    bgt_s = (b ^ sb) > (a ^ sb);
    case (op)
      5'b00000: red_apply = a & b;
      5'b00001: red_apply = a | b;
      5'b00010: red_apply = a ^ b;
      5'b00100: red_apply = bgt_u ? a : b;
      5'b00101: red_apply = bgt_s ? a : b;
      5'b00110: red_apply = bgt_u ? b : a;
      5'b00111: red_apply = bgt_s ? b : a;
      default:  red_apply = a;
    endcase
  endfunction

  assign unsup_c = (red_op[4:3] != 2'b00) || (red_op[2:0] == 3'b011);
  assign maxel_c = IW'(VLEN/8) >> sew;
  assign evl_c   = (vl < maxel_c) ? vl : maxel_c;

  // Fold every active element of the current chunk, lowest index first.
  always_comb begin
    chunk_c = b_q[int'(c_q)*64 +: 64];
    fold_c  = acc_q;
    elem_c  = '0;
    idx_c   = '0;
    act_c   = 1'b0;
    for (int j = 0; j < 8; j++) begin
      elem_c = (chunk_c >> (9'(j) << (3'd3 + 3'(sew_q)))) & sew_mask(sew_q);
      idx_c  = (IW'(c_q) << (3'd3 - 3'(sew_q))) + IW'(j);
      act_c  = (4'(j) < (4'd8 >> sew_q)) && (idx_c < evl_q);
`ifdef VRED_MASK_EN
      act_c  = act_c && vmask_q[idx_c[IW-2:0]];
`endif
      if (act_c) fold_c = red_apply(fold_c, elem_c, op_q, sew_q);
    end
    last_c = ((IW'(c_q) + IW'(1)) << (3'd3 - 3'(sew_q))) >= evl_q;
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    result_d = result_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    sew_d    = sew_q;
    evl_d    = evl_q;
    c_d      = c_q;
    err_d    = err_q;
`ifdef VRED_MASK_EN
    vmask_d  = vmask_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d     = dataB;
          op_d    = red_op;
          sew_d   = sew;
          evl_d   = evl_c;
          err_d   = unsup_c;
          acc_d   = dataA[63:0] & sew_mask(sew);
          c_d     = '0;
`ifdef VRED_MASK_EN
          vmask_d = vmask;
`endif
          state_d = (unsup_c || (evl_c == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        acc_d = fold_c;
        c_d   = c_q + CW'(1);
        if (last_c) state_d = S_DONE;
      end
      S_DONE: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        error_d  = err_q;
        result_d = acc_q;
      end
      default: state_d = S_IDLE;
    endcase
    // busy covers the cycle in which done is presented
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sew_q    <= '0;
      evl_q    <= '0;
      c_q      <= '0;
      err_q    <= 1'b0;
`ifdef VRED_MASK_EN
      vmask_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sew_q    <= sew_d;
      evl_q    <= evl_d;
      c_q      <= c_d;
      err_q    <= err_d;
`ifdef VRED_MASK_EN
      vmask_q  <= vmask_d;
`endif
    end
  end

  // Only element 0 of vs1 is consumed.
  if (VLEN > 64) begin : g_unused
    logic unused_hi_c;
    assign unused_hi_c = ^dataA[VLEN-1:64];
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;
  assign result = result_q;

endmodule
